// File: rtl/ama_riscv_fetch_pkg.sv
// Shared fetch-stage definitions: reset vector, NOP encoding, IMEM address
// widths, PC select encoding and the fetch queue entry.
package ama_riscv_fetch_pkg;

   localparam int unsigned CORE_ADDR_BUS_W = 14;                   // IMEM word address bits
   localparam int unsigned CORE_ADDR_BUS_B = CORE_ADDR_BUS_W + 2;  // IMEM byte address bits
   localparam logic [31:0] RESET_VECTOR    = 32'h0004_0000;
   localparam logic [31:0] NOP             = 32'h0000_0013;        // addi x0, x0, 0

   typedef enum logic [1:0] {
      PC_SEL_PC   = 2'd0,   // hold
      PC_SEL_INC4 = 2'd1,   // sequential
      PC_SEL_ALU  = 2'd2    // redirect from execute
   } pc_sel_t;

   typedef struct packed {
      logic [31:0] inst;
      logic [31:0] pc;
   } fetch_entry_t;

   // Redirect targets are word aligned by dropping the low bits; no trap.
   function automatic logic [31:0] align_pc(input logic [31:0] pc);
      return {pc[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/ama_riscv_fetch_queue.sv
// First-word-fall-through FIFO of fetch entries. Flush wins over push/pop;
// push on a full queue is accepted only when a pop frees the slot that cycle.
module ama_riscv_fetch_queue
   import ama_riscv_fetch_pkg::*;
#(
   parameter int unsigned DEPTH = 2,
   parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          flush_i,
   input  logic          push_i,
   input  logic          pop_i,
   input  fetch_entry_t  din_i,
   output fetch_entry_t  dout_o,
   output logic [CW-1:0] count_o,
   output logic          full_o,
   output logic          empty_o
);

   localparam int unsigned PW = $clog2(DEPTH);

   fetch_entry_t  mem_q [DEPTH];
   logic [PW-1:0] wr_q, rd_q;
   logic [CW-1:0] cnt_q;
   logic          do_push, do_pop;

   assign empty_o = (cnt_q == '0);
   assign full_o  = (cnt_q == CW'(DEPTH));
   assign count_o = cnt_q;
   assign dout_o  = mem_q[rd_q];

   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);

   // Entry storage; no reset needed since count gates visibility
   always_ff @(posedge clk) begin
      if (do_push && !flush_i) mem_q[wr_q] <= din_i;
   end

   // Pointers and occupancy; flush empties the queue in one cycle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else if (flush_i) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (do_push) wr_q <= wr_q + PW'(1);
         if (do_pop)  rd_q <= rd_q + PW'(1);
         cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
      end
   end

endmodule

// File: rtl/ama_riscv_fetch.sv
// Instruction fetch: owns the PC, issues credit-limited IMEM requests, pairs
// in-order responses with their request PCs and queues them for decode.
// Redirects flush the queue and mark in-flight responses for discard.
module ama_riscv_fetch
   import ama_riscv_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = RESET_VECTOR,
   parameter int unsigned FQ_DEPTH  = 2,          // power of two, 2..8
   parameter int unsigned MAX_OUTST = FQ_DEPTH,   // <= FQ_DEPTH
   parameter int unsigned AW        = CORE_ADDR_BUS_W
) (
   input  logic          clk,
   input  logic          rst,
   output logic          imem_req_valid,
   input  logic          imem_req_ready,
   output logic [AW-1:0] imem_req_addr,
   input  logic          imem_rsp_valid,
   input  logic [31:0]   imem_rsp_data,
   input  logic          redir_valid,
   input  logic [31:0]   redir_pc,
   output logic          dec_valid,
   input  logic          dec_ready,
   output logic [31:0]   dec_inst,
   output logic [31:0]   dec_pc
);

   localparam int unsigned OW = $clog2(MAX_OUTST + 1);
   localparam int unsigned CW = $clog2(FQ_DEPTH + 1);
   localparam int unsigned PW = $clog2(FQ_DEPTH);

   logic [31:0]   pc_q, pc_d;
   logic [OW-1:0] outst_q, outst_d;
   logic [OW-1:0] discard_q, discard_d;
   logic          rst_q;
   pc_sel_t       pc_sel;

   logic          req_acc, rsp_take, rsp_drop, fq_push, fq_pop;
   logic          fq_full, fq_empty;
   logic [CW-1:0] fq_cnt;
   fetch_entry_t  fq_din, fq_head;

   // PC FIFO: one entry per outstanding request, popped by every response
   // (kept or dropped), so it is never flushed by a redirect.
   logic [31:0]   pcf_q [FQ_DEPTH];
   logic [PW-1:0] pcf_wr_q, pcf_rd_q;

   assign req_acc  = imem_req_valid && imem_req_ready;
   assign rsp_take = imem_rsp_valid && (outst_q != '0);   // stray responses ignored
   assign rsp_drop = rsp_take && (discard_q != '0);
   assign fq_push  = rsp_take && !rsp_drop;
   assign fq_pop   = dec_valid && dec_ready;

   // Credit rule: every request in flight already owns a queue slot
   assign imem_req_valid = !rst_q && !redir_valid
                        && ((32'(outst_q) + 32'(fq_cnt)) < FQ_DEPTH)
                        && (32'(outst_q) < MAX_OUTST);
   assign imem_req_addr  = pc_q[AW+1:2];

   assign fq_din = '{inst: imem_rsp_data, pc: pcf_q[pcf_rd_q]};

   assign dec_valid = !fq_empty;
   assign dec_inst  = dec_valid ? fq_head.inst : NOP;
   assign dec_pc    = dec_valid ? fq_head.pc   : 32'd0;

   assign outst_d = outst_q + OW'(req_acc) - OW'(rsp_take);

   // Next-PC source: redirect beats sequential advance
   always_comb begin
      pc_sel = PC_SEL_PC;
      if (redir_valid)  pc_sel = PC_SEL_ALU;
      else if (req_acc) pc_sel = PC_SEL_INC4;
   end

   // Next-PC value
   always_comb begin
      pc_d = pc_q;
      case (pc_sel)
         PC_SEL_ALU:  pc_d = align_pc(redir_pc);
         PC_SEL_INC4: pc_d = pc_q + 32'd4;
         default:     pc_d = pc_q;
      endcase
   end

   // Redirect marks everything still in flight as stale
   always_comb begin
      discard_d = discard_q;
      if (redir_valid)   discard_d = outst_d;
      else if (rsp_drop) discard_d = discard_q - OW'(1);
   end

   // Holds off the first request until the cycle after reset release
   always_ff @(posedge clk or posedge rst) begin
      if (rst) rst_q <= 1'b1;
      else     rst_q <= 1'b0;
   end

   // PC and in-flight bookkeeping
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q      <= RESET_PC;
         outst_q   <= '0;
         discard_q <= '0;
      end else begin
         pc_q      <= pc_d;
         outst_q   <= outst_d;
         discard_q <= discard_d;
      end
   end

   // Request PC storage
   always_ff @(posedge clk) begin
      if (req_acc) pcf_q[pcf_wr_q] <= pc_q;
   end

   // Request PC FIFO pointers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pcf_wr_q <= '0;
         pcf_rd_q <= '0;
      end else begin
         if (req_acc)  pcf_wr_q <= pcf_wr_q + PW'(1);
         if (rsp_take) pcf_rd_q <= pcf_rd_q + PW'(1);
      end
   end

   ama_riscv_fetch_queue #(.DEPTH(FQ_DEPTH)) u_fq (
      .clk     (clk),
      .rst     (rst),
      .flush_i (redir_valid),
      .push_i  (fq_push),
      .pop_i   (fq_pop),
      .din_i   (fq_din),
      .dout_o  (fq_head),
      .count_o (fq_cnt),
      .full_o  (fq_full),
      .empty_o (fq_empty)
   );

   // Responses with nothing outstanding are dropped; outside the reset
   // window they indicate an IMEM protocol problem.
   a_no_stray_rsp: assert property (@(posedge clk) disable iff (rst || rst_q)
      !(imem_rsp_valid && (outst_q == '0)));

   a_discard_le_outst: assert property (@(posedge clk) disable iff (rst)
      discard_q <= outst_q);

   a_no_overflow: assert property (@(posedge clk) disable iff (rst)
      !(fq_push && fq_full && !fq_pop && !redir_valid));

endmodule
